// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state encoding and default bus widths
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: wait-state counter that flags the last allowed cycle before timeout
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= (rst || clear) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  generate
    if (TIMEOUT > 0) begin : g_to
      assign expire = en & (cnt_q == W'(TIMEOUT - 1));
    end else begin : g_no_to
      assign expire = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/apb_cmd_initiator.sv
// apb_cmd_initiator: valid/ready command stream to APB transfers with registered responses
module apb_cmd_initiator
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);
  apb_state_e        state_q;
  logic              psel_q, penable_q, pwrite_q, rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
  logic              accept, wait_en, expire;
  assign cmd_ready   = (state_q == IDLE) & ~rst;
  assign accept      = cmd_valid & cmd_ready;
  assign wait_en     = (state_q == ACCESS) & ~pready;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .en     (wait_en),
    .expire (expire)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          pwrite_q <= cmd_write;
          paddr_q  <= cmd_addr;
          pwdata_q <= cmd_wdata;
          psel_q   <= 1'b1;
          state_q  <= SETUP;
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: if (pready || expire) begin
          psel_q        <= 1'b0;
          penable_q     <= 1'b0;
          rsp_valid_q   <= 1'b1;
          rsp_rdata_q   <= (pready && !pwrite_q) ? prdata : '0;
          rsp_err_q     <= pready ? pslverr : 1'b1;
          rsp_timeout_q <= ~pready;
          state_q       <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_initiator.sv
// tb_apb_cmd_initiator: directed vector table plus hand sequences for backpressure and reset
module tb_apb_cmd_initiator;
  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_write, rsp_ready, pready, pslverr;
  logic [7:0] cmd_addr, cmd_wdata, prdata;
  logic       cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite;
  logic [7:0] rsp_rdata, paddr, pwdata;
  int         checks = 0;
  int         failures = 0;
  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] prdata;
    int         waits;
    logic       err;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic       exp_to;
    int         exp_acc;
  } vec_t;
  vec_t vecs[7];
  apb_cmd_initiator #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int acc;
    bit done;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    rsp_ready = 1'b1;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 8'hEE;
    #1 chk("vec_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = ~v.wr;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    chk("vec_setup_psel", psel, 1);
    chk("vec_setup_penable", penable, 0);
    chk("vec_setup_paddr", paddr, v.addr);
    chk("vec_setup_pwrite", pwrite, v.wr);
    if (v.wr) chk("vec_setup_pwdata", pwdata, v.wdata);
    acc  = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (psel && penable) begin
        acc++;
        chk("vec_access_paddr", paddr, v.addr);
        pready  = (acc == v.waits + 1);
        prdata  = pready ? v.prdata : 8'hEE;
        pslverr = pready & v.err;
      end else done = 1'b1;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    chk("vec_access_cycles", acc, v.exp_acc);
    chk("vec_rsp_valid", rsp_valid, 1);
    chk("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("vec_rsp_err", rsp_err, v.exp_err);
    chk("vec_rsp_timeout", rsp_timeout, v.exp_to);
    chk("vec_resp_psel", psel, 0);
    @(negedge clk);
    chk("vec_rsp_drop", rsp_valid, 0);
    chk("vec_ready_again", cmd_ready, 1);
    chk("vec_idle_paddr_hold", paddr, v.addr);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{1'b1, 8'h10, 8'hA5, 8'h77, 0,  1'b0, 8'h00, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 8'h90, 8'h00, 8'h3C, 3,  1'b0, 8'h3C, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 8'h22, 8'h00, 8'h5A, 1,  1'b1, 8'h5A, 1'b1, 1'b0, 2};
    vecs[3] = '{1'b0, 8'h33, 8'h00, 8'h44, 99, 1'b0, 8'h00, 1'b1, 1'b1, 16};
    vecs[4] = '{1'b0, 8'h44, 8'h00, 8'hC3, 15, 1'b0, 8'hC3, 1'b0, 1'b0, 16};
    vecs[5] = '{1'b1, 8'hFF, 8'h00, 8'h12, 2,  1'b1, 8'h00, 1'b1, 1'b0, 3};
    vecs[6] = '{1'b1, 8'h01, 8'h5F, 8'h34, 99, 1'b0, 8'h00, 1'b1, 1'b1, 16};
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55; rsp_ready = 1'b0; pready = 1'b0;
    #1 chk("bp_first_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 8'h66; cmd_wdata = 8'h99;
    chk("bp_busy_setup", cmd_ready, 0);
    @(negedge clk);
    pready = 1'b1; prdata = 8'h81;
    chk("bp_busy_access", cmd_ready, 0);
    @(negedge clk);
    pready = 1'b0; prdata = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_rdata", rsp_rdata, 8'h81);
      chk("bp_hold_err", rsp_err, 0);
      chk("bp_hold_cmd_ready", cmd_ready, 0);
      chk("bp_hold_psel", psel, 0);
      @(negedge clk);
    end
    chk("bp_still_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_rsp_drop", rsp_valid, 0);
    chk("bp_second_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_second_psel", psel, 1);
    chk("bp_second_paddr", paddr, 8'h66);
    chk("bp_second_pwrite", pwrite, 1);
    chk("bp_second_pwdata", pwdata, 8'h99);
    @(negedge clk);
    pready = 1'b1;
    @(negedge clk);
    pready = 1'b0;
    chk("bp_second_valid", rsp_valid, 1);
    chk("bp_second_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_drop", rsp_valid, 0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rs_in_access", penable, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_psel", psel, 0);
    chk("rs_penable", penable, 0);
    chk("rs_rsp_valid", rsp_valid, 0);
    chk("rs_cmd_ready_in_rst", cmd_ready, 0);
    rst = 1'b0; pready = 1'b1; prdata = 8'h11;
    #1 chk("rs_cmd_ready_after", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rs_no_response", rsp_valid, 0);
      chk("rs_idle_psel", psel, 0);
    end
    pready = 1'b0;
    rst = 1'b1; cmd_valid = 1'b1;
    #1 chk("rs_cmd_ready_rst_wins", cmd_ready, 0);
    @(negedge clk);
    chk("rs_no_accept", psel, 0);
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("rs_still_idle", psel, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
